// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first,
// with a three-state IDLE/RUN/DONE controller and registered result outputs.

module serial_sub_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic br_i,
  output logic d_o,
  output logic br_o
);
  assign d_o  = a_i ^ b_i ^ br_i;
  assign br_o = (~a_i & b_i) | (~(a_i ^ b_i) & br_i);
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d, diff_q, diff_d;
  logic             bout_q, bout_d, busy_q, busy_d, done_q, done_d;
  logic             d_bit, br_nxt, accept;

  // Operand registers shift right so the active bit is always at index 0.
  serial_sub_cell u_cell (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .br_i(br_q),
    .d_o (d_bit),
    .br_o(br_nxt)
  );

  // abort outranks start even outside RUN
  assign accept = start && !abort && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    a_d     = a_q;
    b_d     = b_q;
    sr_d    = sr_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          a_d  = a_q >> 1;
          b_d  = b_q >> 1;
          br_d = br_nxt;
          sr_d = {d_bit, sr_q[WIDTH-1:1]};
          if (cnt_q == LAST) begin
            state_d = DONE;
            diff_d  = {d_bit, sr_q[WIDTH-1:1]};
            bout_d  = br_nxt;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        if (accept) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sr_q    <= sr_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl (WIDTH=8): table of subtraction vectors
// plus hand-written back-to-back, ignored-start, abort and reset sequences.

module tb_serial_sub_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout;
  logic [W-1:0] diff;

  int checks = 0;
  int errors = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    a = av; b = bv; bin = bi; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for done (bounded); e0 = edges already elapsed since the start edge.
  task automatic finish(input int e0, input logic [W-1:0] ed, input logic eb, input string nm);
    int edges = e0;
    int bc = e0;
    logic [W-1:0] d0 = diff;
    logic stable = 1'b1;
    while (!done && edges < 20) begin
      if (busy) bc++;
      if (diff !== d0) stable = 1'b0;
      tick();
      edges++;
    end
    chk({nm, " done_seen"}, {31'd0, done}, 32'd1);
    chk({nm, " latency"}, edges, W);
    chk({nm, " busy_cycles"}, bc, W);
    chk({nm, " diff_stable_in_run"}, {31'd0, stable}, 32'd1);
    chk({nm, " diff"}, {24'd0, diff}, {24'd0, ed});
    chk({nm, " bout"}, {31'd0, bout}, {31'd0, eb});
    chk({nm, " busy_in_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic single_pulse(input string nm);
    tick();
    chk({nm, " done_single"}, {31'd0, done}, 32'd0);
  endtask

  task automatic no_done(input string nm, input int n);
    logic seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (done) seen = 1'b1;
      tick();
    end
    chk({nm, " no_done"}, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0};
    vecs[5] = '{8'h10, 8'h01, 1'b1, 8'h0E, 1'b0};

    #1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst diff", {24'd0, diff}, 32'd0);
    chk("rst bout", {31'd0, bout}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      go(vecs[i].a, vecs[i].b, vecs[i].bin);
      chk($sformatf("vec%0d busy_after_start", i), {31'd0, busy}, 32'd1);
      finish(0, vecs[i].d, vecs[i].bo, $sformatf("vec%0d", i));
      single_pulse($sformatf("vec%0d", i));
    end

    // Back-to-back: start held in the DONE cycle.
    go(8'h00, 8'h01, 1'b0);
    finish(0, 8'hFF, 1'b1, "b2b_first");
    a = 8'h80; b = 8'h7F; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b done_dropped", {31'd0, done}, 32'd0);
    chk("b2b busy_again", {31'd0, busy}, 32'd1);
    chk("b2b first_result_held", {24'd0, diff}, 32'hFF);
    finish(0, 8'h01, 1'b0, "b2b_second");
    single_pulse("b2b_second");

    // start with new operands in cycle 3 of RUN is ignored.
    go(8'h05, 8'h03, 1'b0);
    tick(); tick();
    a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    finish(3, 8'h02, 1'b0, "ign_start");
    single_pulse("ign_start");

    // Abort at cycle 4 of RUN: back to IDLE, prior result kept.
    go(8'hA5, 8'h5A, 1'b0);
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort diff_kept", {24'd0, diff}, 32'h02);
    chk("abort bout_kept", {31'd0, bout}, 32'd0);
    no_done("abort", 12);

    // abort beats start in IDLE.
    a = 8'h09; b = 8'h01; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_prio busy", {31'd0, busy}, 32'd0);
    no_done("abort_prio", 12);

    // Reset mid-RUN at cycle 5.
    go(8'h00, 8'h01, 1'b0);
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst diff", {24'd0, diff}, 32'd0);
    chk("midrst bout", {31'd0, bout}, 32'd0);
    tick();
    rst_n = 1'b1;
    no_done("midrst", 12);

    // First start after reset release is accepted.
    go(8'h10, 8'h01, 1'b1);
    chk("post_rst busy", {31'd0, busy}, 32'd1);
    finish(0, 8'h0E, 1'b0, "post_rst");
    single_pulse("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
